// File: rtl/rst_sequencer_pkg.sv
// Shared types and helpers for the reset sequencer.
//   seq_state_e : sequencer FSM states
//   cnt_width() : width of the shared cycle counter
package rst_sequencer_pkg;

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        HOLD      = 3'd1,
        WAIT_ACK  = 3'd2,
        GAP       = 3'd3,
        RUN       = 3'd4,
        DRAIN     = 3'd5,
        FAULT     = 3'd6
    } seq_state_e;

    // Wide enough to hold the largest terminal count of any timed phase.
    function automatic int unsigned cnt_width(input int unsigned hold_c,
                                              input int unsigned gap_c,
                                              input int unsigned timeout_c);
        int unsigned m;
        m = hold_c;
        if (gap_c > m) begin
            m = gap_c;
        end
        if (timeout_c > m) begin
            m = timeout_c;
        end
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/rst_ack_sync.sv
// Multi-flop synchronizer for one asynchronous acknowledge bit.
//   clk_i : sequencer clock
//   rst_i : synchronous active-high reset, clears all stages to 0
//   d_i   : asynchronous input bit
//   q_o   : synchronized output (last flop of the chain)
module rst_ack_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    // Shift chain; bit 0 is the metastability-exposed capture flop.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/rst_sequencer.sv
// Power-on / soft-reset sequencer for several reset domains.
// Releases active-low domain resets in ascending order, waiting for each
// domain's synchronized reset to come back as an acknowledge, and drains
// them in descending order on a software request from RUN.
//   CLK_I      : free-running sequencer clock
//   RST_I      : synchronous active-high reset
//   LOCK_I     : clock source locked (synchronous)
//   SW_RST_I   : software reset request, single-cycle pulse
//   ACK_I      : per-domain acknowledge, asynchronous
//   NRST_O     : per-domain reset request, active-low, thermometer-coded
//   BUSY_O     : sequence in progress (not RUN, not FAULT)
//   DONE_O     : all domains released and acknowledged
//   TIMEOUT_O  : sticky acknowledge timeout flag
//   FAIL_IDX_O : domain that timed out, valid while TIMEOUT_O=1
module rst_sequencer
    import rst_sequencer_pkg::*;
#(
    parameter int unsigned DOMAINS        = 3,
    parameter int unsigned HOLD_CYCLES    = 16,
    parameter int unsigned GAP_CYCLES     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic                       CLK_I,
    input  logic                       RST_I,
    input  logic                       LOCK_I,
    input  logic                       SW_RST_I,
    input  logic [DOMAINS-1:0]         ACK_I,
    output logic [DOMAINS-1:0]         NRST_O,
    output logic                       BUSY_O,
    output logic                       DONE_O,
    output logic                       TIMEOUT_O,
    output logic [$clog2(DOMAINS)-1:0] FAIL_IDX_O
);

    localparam int unsigned IDX_W = $clog2(DOMAINS);
    localparam int unsigned CNT_W = cnt_width(HOLD_CYCLES, GAP_CYCLES, TIMEOUT_CYCLES);

    // Terminal counts: the phase ends on the edge that sees cnt_q at N-1,
    // i.e. exactly N edges after the entry edge that cleared the counter.
    localparam logic [CNT_W-1:0] HOLD_TC  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_TC   = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_TC   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DOMAINS - 1);

    seq_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   cnt_inc;
    logic [IDX_W-1:0]   k_q, k_d;
    logic [IDX_W-1:0]   k_nxt, k_prv;
    logic [DOMAINS-1:0] nrst_q, nrst_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               timeout_q, timeout_d;
    logic [IDX_W-1:0]   fail_idx_q, fail_idx_d;
    logic [DOMAINS-1:0] ack_sync;

    // One synchronizer per domain acknowledge.
    for (genvar i = 0; i < DOMAINS; i++) begin : g_ack_sync
        rst_ack_sync #(
            .STAGES (SYNC_STAGES)
        ) u_ack_sync (
            .clk_i (CLK_I),
            .rst_i (RST_I),
            .d_i   (ACK_I[i]),
            .q_o   (ack_sync[i])
        );
    end

    // Saturating increment; phases always exit before saturation matters.
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    assign k_nxt   = k_q + IDX_W'(1);
    assign k_prv   = k_q - IDX_W'(1);

    // State and output registers.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_q    <= WAIT_LOCK;
            cnt_q      <= '0;
            k_q        <= '0;
            nrst_q     <= '0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
            fail_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            k_q        <= k_d;
            nrst_q     <= nrst_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            timeout_q  <= timeout_d;
            fail_idx_q <= fail_idx_d;
        end
    end

    // Next state and next output values; lock loss beats software reset.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_inc;
        k_d        = k_q;
        nrst_d     = nrst_q;
        done_d     = done_q;
        timeout_d  = timeout_q;
        fail_idx_d = fail_idx_q;

        if (!LOCK_I) begin
            // Timeout flag survives lock loss; only the sequence restarts.
            state_d = WAIT_LOCK;
            cnt_d   = '0;
            k_d     = '0;
            nrst_d  = '0;
            done_d  = 1'b0;
        end else if (SW_RST_I && (state_q != WAIT_LOCK)) begin
            cnt_d     = '0;
            done_d    = 1'b0;
            timeout_d = 1'b0;
            if (state_q == RUN) begin
                // Start a descending drain with the highest domain.
                state_d          = DRAIN;
                k_d              = LAST_IDX;
                nrst_d[LAST_IDX] = 1'b0;
            end else begin
                state_d = HOLD;
                k_d     = '0;
                nrst_d  = '0;
            end
        end else begin
            unique case (state_q)
                WAIT_LOCK: begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end
                HOLD: begin
                    if (cnt_q == HOLD_TC) begin
                        state_d   = WAIT_ACK;
                        cnt_d     = '0;
                        k_d       = '0;
                        nrst_d[0] = 1'b1;
                    end
                end
                WAIT_ACK: begin
                    // An acknowledge arriving on the timeout edge still wins.
                    if (ack_sync[k_q]) begin
                        cnt_d = '0;
                        if (k_q == LAST_IDX) begin
                            state_d = RUN;
                            done_d  = 1'b1;
                        end else begin
                            state_d = GAP;
                        end
                    end else if (cnt_q == TMO_TC) begin
                        state_d    = FAULT;
                        cnt_d      = '0;
                        nrst_d     = '0;
                        timeout_d  = 1'b1;
                        fail_idx_d = k_q;
                    end
                end
                GAP: begin
                    if (cnt_q == GAP_TC) begin
                        state_d       = WAIT_ACK;
                        cnt_d         = '0;
                        k_d           = k_nxt;
                        nrst_d[k_nxt] = 1'b1;
                    end
                end
                DRAIN: begin
                    if (cnt_q == GAP_TC) begin
                        cnt_d         = '0;
                        k_d           = k_prv;
                        nrst_d[k_prv] = 1'b0;
                        if (k_prv == '0) begin
                            state_d = HOLD;
                        end
                    end
                end
                RUN, FAULT: begin
                    cnt_d = cnt_q;
                end
                default: begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                    k_d     = '0;
                    nrst_d  = '0;
                    done_d  = 1'b0;
                end
            endcase
        end

        busy_d = !((state_d == RUN) || (state_d == FAULT));
    end

    assign NRST_O     = nrst_q;
    assign BUSY_O     = busy_q;
    assign DONE_O     = done_q;
    assign TIMEOUT_O  = timeout_q;
    assign FAIL_IDX_O = fail_idx_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// Bench for rst_sequencer: directed scenarios with hand-computed edge
// numbers, then randomized lock/software/acknowledge stimulus, all checked
// every cycle against a deadline-based behavioural model.
module tb_rst_sequencer;

    localparam int D  = 3;
    localparam int H  = 16;
    localparam int G  = 4;
    localparam int T  = 64;
    localparam int S  = 2;
    localparam int IW = $clog2(D);

    localparam int M_IDLE  = 0;
    localparam int M_HOLD  = 1;
    localparam int M_WAIT  = 2;
    localparam int M_GAP   = 3;
    localparam int M_RUN   = 4;
    localparam int M_DRAIN = 5;
    localparam int M_FAULT = 6;

    logic          clk  = 1'b0;
    logic          rst  = 1'b0;
    logic          lock = 1'b0;
    logic          sw   = 1'b0;
    logic [D-1:0]  ack  = '0;
    logic [D-1:0]  nrst;
    logic          busy;
    logic          done;
    logic          tmo;
    logic [IW-1:0] fidx;

    rst_sequencer #(
        .DOMAINS        (D),
        .HOLD_CYCLES    (H),
        .GAP_CYCLES     (G),
        .TIMEOUT_CYCLES (T),
        .SYNC_STAGES    (S)
    ) dut (
        .CLK_I      (clk),
        .RST_I      (rst),
        .LOCK_I     (lock),
        .SW_RST_I   (sw),
        .ACK_I      (ack),
        .NRST_O     (nrst),
        .BUSY_O     (busy),
        .DONE_O     (done),
        .TIMEOUT_O  (tmo),
        .FAIL_IDX_O (fidx)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Model: released-domain count plus an absolute deadline per phase.
    int           m_mode = M_IDLE;
    int           m_n    = 0;
    int           m_due  = 0;
    int           m_fidx = 0;
    logic         m_done = 1'b0;
    logic         m_to   = 1'b0;
    logic [D-1:0] m_ackq [S] = '{default: '0};

    // Acknowledge generation: NRST_O delayed two cycles, or random bits.
    logic [D-1:0] p0 = '0;
    logic [D-1:0] p1 = '0;
    logic [D-1:0] stuck = '0;
    int           ack_mode = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s at edge %0d: got %0h expected %0h", name, cyc, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (ack_mode == 0) begin
            ack = p1 & ~stuck;
        end else begin
            ack = D'($urandom);
        end
        p1 = p0;
        p0 = nrst;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) begin
            tick();
        end
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && !done; i++) begin
            tick();
        end
        check("wait_done", 64'(done), 64'(1'b1));
    endtask

    task automatic wait_bit(input int b, input int budget);
        for (int i = 0; i < budget && !nrst[b]; i++) begin
            tick();
        end
        check("wait_nrst_bit", 64'(nrst[b]), 64'(1'b1));
    endtask

    always @(posedge clk) begin : ref_model
        logic [D-1:0] syn;
        cyc = cyc + 1;
        syn = m_ackq[0];
        if (rst) begin
            m_mode = M_IDLE;
            m_n    = 0;
            m_done = 1'b0;
            m_to   = 1'b0;
            m_fidx = 0;
        end else if (!lock) begin
            if (m_mode != M_IDLE) begin
                m_mode = M_IDLE;
                m_n    = 0;
                m_done = 1'b0;
            end
        end else if (sw && m_mode != M_IDLE) begin
            m_done = 1'b0;
            m_to   = 1'b0;
            if (m_mode == M_RUN) begin
                m_mode = M_DRAIN;
                m_n    = D - 1;
                m_due  = cyc + G;
            end else begin
                m_mode = M_HOLD;
                m_n    = 0;
                m_due  = cyc + H;
            end
        end else begin
            case (m_mode)
                M_IDLE: begin
                    m_mode = M_HOLD;
                    m_due  = cyc + H;
                end
                M_HOLD: if (cyc == m_due) begin
                    m_n    = 1;
                    m_mode = M_WAIT;
                    m_due  = cyc + T;
                end
                M_WAIT: begin
                    if (syn[m_n-1]) begin
                        if (m_n == D) begin
                            m_mode = M_RUN;
                            m_done = 1'b1;
                        end else begin
                            m_mode = M_GAP;
                            m_due  = cyc + G;
                        end
                    end else if (cyc == m_due) begin
                        m_to   = 1'b1;
                        m_fidx = m_n - 1;
                        m_n    = 0;
                        m_mode = M_FAULT;
                    end
                end
                M_GAP: if (cyc == m_due) begin
                    m_n    = m_n + 1;
                    m_mode = M_WAIT;
                    m_due  = cyc + T;
                end
                M_DRAIN: if (cyc == m_due) begin
                    m_n = m_n - 1;
                    if (m_n == 0) begin
                        m_mode = M_HOLD;
                        m_due  = cyc + H;
                    end else begin
                        m_due = cyc + G;
                    end
                end
                default: ;
            endcase
        end
        if (rst) begin
            m_ackq = '{default: '0};
        end else begin
            for (int i = 0; i < S - 1; i++) begin
                m_ackq[i] = m_ackq[i+1];
            end
            m_ackq[S-1] = ack;
        end
    end

    always @(negedge clk) begin : compare
        logic [D-1:0] e_nrst;
        logic         e_busy;
        logic         therm_ok;
        logic         done_ok;
        int           nv;
        if (cyc >= 1) begin
            e_nrst = D'((1 << m_n) - 1);
            e_busy = (m_mode != M_RUN) && (m_mode != M_FAULT);
            check("outputs", 64'({nrst, done, busy, tmo, fidx}),
                  64'({e_nrst, m_done, e_busy, m_to, IW'(m_fidx)}));
            nv       = int'(nrst);
            therm_ok = ((nv & (nv + 1)) == 0);
            done_ok  = !done || (nrst == '1);
            check("invariant", 64'({therm_ok, done_ok}), 64'(2'b11));
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at edge %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int e;
        int r;
        int f;
        int lk;

        // Power-on: reset edges 1-2, lock sampled from edge 5.
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("reset_state", 64'({nrst, done, busy, tmo, fidx}), 64'({3'b000, 1'b0, 1'b1, 1'b0, 2'b00}));
        tick();
        tick();
        lock = 1'b1;
        run_to(20);
        check("hold_e20", 64'(nrst), 64'(3'b000));
        tick();
        check("rel0_e21", 64'(nrst), 64'(3'b001));
        check("model_e21", 64'(D'((1 << m_n) - 1)), 64'(3'b001));
        run_to(29);
        check("gap_e29", 64'(nrst), 64'(3'b001));
        tick();
        check("rel1_e30", 64'(nrst), 64'(3'b011));
        run_to(38);
        check("gap_e38", 64'(nrst), 64'(3'b011));
        tick();
        check("rel2_e39", 64'({nrst, done}), 64'({3'b111, 1'b0}));
        run_to(43);
        check("wait_e43", 64'({done, busy}), 64'(2'b01));
        tick();
        check("done_e44", 64'({done, busy}), 64'(2'b10));
        check("model_e44", 64'(m_done), 64'(1'b1));

        // Software drain from RUN and re-release.
        sw = 1'b1;
        tick();
        sw = 1'b0;
        e = cyc;
        check("drain_e", 64'({nrst, done, busy}), 64'({3'b011, 1'b0, 1'b1}));
        run_to(e + 3);
        check("drain_e3", 64'(nrst), 64'(3'b011));
        tick();
        check("drain_e4", 64'(nrst), 64'(3'b001));
        run_to(e + 7);
        check("drain_e7", 64'(nrst), 64'(3'b001));
        tick();
        check("drain_e8", 64'(nrst), 64'(3'b000));
        run_to(e + 23);
        check("rehold_e23", 64'(nrst), 64'(3'b000));
        tick();
        check("rerel_e24", 64'(nrst), 64'(3'b001));
        wait_done(100);

        // Domain 1 never acknowledges.
        stuck = 3'b010;
        sw = 1'b1;
        tick();
        sw = 1'b0;
        e = cyc;
        run_to(e + 9);
        wait_bit(1, 100);
        r = cyc;
        run_to(r + 63);
        check("pre_timeout", 64'({nrst, tmo}), 64'({3'b011, 1'b0}));
        tick();
        check("timeout", 64'({nrst, tmo, fidx, busy, done}), 64'({3'b000, 1'b1, 2'b01, 1'b0, 1'b0}));
        run_to(r + 70);
        check("fault_hold", 64'({nrst, tmo, busy}), 64'({3'b000, 1'b1, 1'b0}));
        stuck = '0;
        sw = 1'b1;
        tick();
        sw = 1'b0;
        f = cyc;
        check("fault_clear", 64'({nrst, tmo, busy}), 64'({3'b000, 1'b0, 1'b1}));
        run_to(f + 15);
        check("fault_hold15", 64'(nrst), 64'(3'b000));
        tick();
        check("fault_rel16", 64'(nrst), 64'(3'b001));
        wait_done(200);

        // Lock lost in the gap after domain 0 acknowledges.
        sw = 1'b1;
        tick();
        sw = 1'b0;
        e = cyc;
        run_to(e + 24);
        r = cyc;
        check("s4_rise", 64'(nrst), 64'(3'b001));
        run_to(r + 6);
        lock = 1'b0;
        tick();
        check("lock_loss", 64'({nrst, done, busy}), 64'({3'b000, 1'b0, 1'b1}));
        tick();
        tick();
        lock = 1'b1;
        tick();
        lk = cyc;
        run_to(lk + 15);
        check("relock_15", 64'(nrst), 64'(3'b000));
        tick();
        check("relock_16", 64'(nrst), 64'(3'b001));
        wait_done(200);

        // Lock loss and software reset together, then hard reset in RUN.
        sw   = 1'b1;
        lock = 1'b0;
        tick();
        sw = 1'b0;
        check("lock_beats_sw", 64'({nrst, done, busy}), 64'({3'b000, 1'b0, 1'b1}));
        tick();
        tick();
        check("lock_beats_sw2", 64'(nrst), 64'(3'b000));
        lock = 1'b1;
        wait_done(200);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_in_run", 64'({nrst, done, busy, tmo, fidx}), 64'({3'b000, 1'b0, 1'b1, 1'b0, 2'b00}));

        // Randomized lock, software, reset and acknowledge activity.
        lk = 0;
        for (int i = 0; i < 10000; i++) begin
            if (i % 300 == 0) begin
                ack_mode = ($urandom_range(0, 3) == 0) ? 1 : 0;
                stuck    = ($urandom_range(0, 2) == 0) ? D'($urandom) : '0;
            end
            if (lk > 0) begin
                lk--;
                lock = (lk == 0);
            end else if ($urandom_range(0, 399) == 0) begin
                lk   = int'($urandom_range(1, 20));
                lock = 1'b0;
            end
            sw  = ($urandom_range(0, 119) == 0);
            rst = ($urandom_range(0, 2999) == 0);
            tick();
        end
        sw  = 1'b0;
        rst = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
